// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution controller: FSM states, the bit layout of the
// packed datapath control word, and memory-port / row-index constants.
package conv_ctrl_pkg;

   // Number of bits in the packed control word.
   localparam int unsigned CTRL_FIELDS = 30;

   // Bit positions inside the control word (2-bit fields occupy [pos +: 2]).
   localparam int unsigned X_SEL          = 0;   // [1:0] x address counter source
   localparam int unsigned X_EN           = 2;
   localparam int unsigned Y_SEL          = 3;   // [4:3] y address counter source
   localparam int unsigned Y_EN           = 5;
   localparam int unsigned Z_SEL          = 6;   // [7:6] z address counter source
   localparam int unsigned Z_EN           = 8;
   localparam int unsigned FILT_LD        = 9;
   localparam int unsigned TAB_COUNT_LD   = 10;
   localparam int unsigned TABLE_LD       = 11;
   localparam int unsigned FILT_COUNT_EN  = 12;
   localparam int unsigned FILT_ROW_SEL   = 13;
   localparam int unsigned INPUT_COUNT_EN = 14;
   localparam int unsigned INPUT_EN       = 15;
   localparam int unsigned COUNT_13_EN    = 16;
   localparam int unsigned MAC_LD         = 17;
   localparam int unsigned CALC_COUNT_EN  = 18;
   localparam int unsigned WR_COUNT_EN    = 19;
   localparam int unsigned WRITE_BUF_LD   = 20;
   localparam int unsigned MAC_RST        = 21;
   localparam int unsigned WR_DATA_SEL    = 22;
   localparam int unsigned SHIFT_EN       = 23;
   localparam int unsigned IN_COUNT_EN    = 24;
   localparam int unsigned IN_COUNT_LD    = 25;
   localparam int unsigned INPUT_I_SEL    = 26;  // [27:26] input row select
   localparam int unsigned MEM_IN_SEL     = 28;  // [29:28] memory address source

   // Address counter source: load base address or post-increment.
   localparam logic [1:0] ADDR_SEL_BASE = 2'd0;
   localparam logic [1:0] ADDR_SEL_INC  = 2'd1;

   // Memory address source select.
   localparam logic [1:0] MEM_SEL_X = 2'd0;
   localparam logic [1:0] MEM_SEL_Y = 2'd1;
   localparam logic [1:0] MEM_SEL_Z = 2'd2;

   // Last row of the 4x4 window.
   localparam logic [1:0] ROW_LAST = 2'd3;

   typedef enum logic [3:0] {
      StIdle,
      StInit,
      StFiltRd,
      StInRd,
      StTabLd,
      StCalc,
      StWrBuf,
      StWrMem,
      StShift,
      StInRd1,
      StFlush,
      StDone
   } conv_state_e;

endpackage

// File: rtl/conv_ctrl_decode.sv
// Pure combinational decoder from controller state to the packed datapath control word
// and the memory strobes. The row index and write fill count only qualify fields, so
// every output remains a function of controller-held state.
module conv_ctrl_decode
   import conv_ctrl_pkg::*;
(
   input  conv_state_e            state,
   input  logic [1:0]             row_idx,
   input  logic [1:0]             wr_fill,
   output logic [CTRL_FIELDS-1:0] ctrl,
   output logic                   mem_read,
   output logic                   mem_write
);

   // Decode one control word per state; everything not listed stays low.
   always_comb begin
      ctrl      = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      unique case (state)
         StIdle: begin
            // Keep the accumulator cleared while parked.
            ctrl[MAC_RST] = 1'b1;
         end
         StInit: begin
            ctrl[X_SEL +: 2]    = ADDR_SEL_BASE;
            ctrl[X_EN]          = 1'b1;
            ctrl[Y_SEL +: 2]    = ADDR_SEL_BASE;
            ctrl[Y_EN]          = 1'b1;
            ctrl[Z_SEL +: 2]    = ADDR_SEL_BASE;
            ctrl[Z_EN]          = 1'b1;
            ctrl[TAB_COUNT_LD]  = 1'b1;
            ctrl[IN_COUNT_LD]   = 1'b1;
            ctrl[MAC_RST]       = 1'b1;
         end
         StFiltRd: begin
            ctrl[MEM_IN_SEL +: 2] = MEM_SEL_X;
            mem_read              = 1'b1;
            ctrl[FILT_LD]         = 1'b1;
            ctrl[FILT_COUNT_EN]   = 1'b1;
            ctrl[FILT_ROW_SEL]    = 1'b0;
            ctrl[X_SEL +: 2]      = ADDR_SEL_INC;
            ctrl[X_EN]            = 1'b1;
         end
         StInRd, StInRd1: begin
            // Full refetch and single-word refresh differ only in how the FSM
            // walks row_idx; the datapath controls are identical.
            ctrl[MEM_IN_SEL +: 2]  = MEM_SEL_Y;
            mem_read               = 1'b1;
            ctrl[INPUT_EN]         = 1'b1;
            ctrl[INPUT_COUNT_EN]   = 1'b1;
            ctrl[INPUT_I_SEL +: 2] = row_idx;
            ctrl[Y_SEL +: 2]       = ADDR_SEL_INC;
            ctrl[Y_EN]             = 1'b1;
         end
         StTabLd: begin
            ctrl[TABLE_LD] = 1'b1;
            ctrl[MAC_RST]  = 1'b1;
         end
         StCalc: begin
            ctrl[FILT_ROW_SEL]  = 1'b1;
            ctrl[CALC_COUNT_EN] = 1'b1;
            ctrl[MAC_LD]        = 1'b1;
         end
         StWrBuf: begin
            ctrl[WRITE_BUF_LD] = 1'b1;
            ctrl[WR_COUNT_EN]  = 1'b1;
         end
         StWrMem: begin
            ctrl[MEM_IN_SEL +: 2] = MEM_SEL_Z;
            mem_write             = 1'b1;
            ctrl[WR_DATA_SEL]     = 1'b0;
            ctrl[Z_SEL +: 2]      = ADDR_SEL_INC;
            ctrl[Z_EN]            = 1'b1;
         end
         StShift: begin
            ctrl[SHIFT_EN]    = 1'b1;
            ctrl[COUNT_13_EN] = 1'b1;
            ctrl[IN_COUNT_EN] = 1'b1;
         end
         StFlush: begin
            // Only a partially filled buffer has anything left to write.
            if (wr_fill != 2'd0) begin
               ctrl[MEM_IN_SEL +: 2] = MEM_SEL_Z;
               mem_write             = 1'b1;
               ctrl[WR_DATA_SEL]     = 1'b1;
            end
         end
         StDone: begin
            ctrl = '0;
         end
         default: begin
            ctrl[MAC_RST] = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/conv_controller.sv
// Main sequencer for one convolution run. Holds the FSM state, the input row index used
// while fetching the window, and the write-buffer fill count used to decide whether a
// final partial flush is needed.
module conv_controller
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned CTRL_W = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              filt_cout,
   input  logic              input_j_cout,
   input  logic              calc_done,
   input  logic              write_mem_cout,
   input  logic              table_cout,
   input  logic              it_ends,
   output logic [CTRL_W-1:0] ctrl,
   output logic              mem_read,
   output logic              mem_write,
   output logic              busy,
   output logic              done
);

   // Elaboration guards: the control word layout is fixed by the package.
   if (CTRL_W != CTRL_FIELDS) begin : g_ctrl_w_check
      $error("conv_controller: CTRL_W must equal CTRL_FIELDS");
   end
   if (ADDR_W == 0) begin : g_addr_w_check
      $error("conv_controller: ADDR_W must be non-zero");
   end

   conv_state_e state_q, state_d;
   logic [1:0]  row_q, row_d;
   logic [1:0]  fill_q, fill_d;
   logic [CTRL_FIELDS-1:0] ctrl_word;

   // State, row index and fill count registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         row_q   <= 2'd0;
         fill_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         fill_q  <= fill_d;
      end
   end

   // Next-state logic plus row-index and fill-count updates.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      fill_d  = fill_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StInit;
         end
         StInit: begin
            row_d   = 2'd0;
            fill_d  = 2'd0;
            state_d = StFiltRd;
         end
         StFiltRd: begin
            if (filt_cout) state_d = StInRd;
         end
         StInRd: begin
            // Four words per row; the datapath flags the last word of each row.
            if (input_j_cout) begin
               if (row_q == ROW_LAST) begin
                  row_d   = 2'd0;
                  state_d = StTabLd;
               end else begin
                  row_d = row_q + 2'd1;
               end
            end
         end
         StInRd1: begin
            // One new word per row after a single-column shift.
            if (row_q == ROW_LAST) begin
               row_d   = 2'd0;
               state_d = StTabLd;
            end else begin
               row_d = row_q + 2'd1;
            end
         end
         StTabLd: begin
            state_d = StCalc;
         end
         StCalc: begin
            if (calc_done) state_d = StWrBuf;
         end
         StWrBuf: begin
            // Fill count tracks the datapath write counter and wraps with it.
            if (write_mem_cout) begin
               fill_d  = 2'd0;
               state_d = StWrMem;
            end else begin
               fill_d  = fill_q + 2'd1;
               state_d = StShift;
            end
         end
         StWrMem: begin
            state_d = StShift;
         end
         StShift: begin
            // End of image wins over end of a window row.
            if (it_ends) begin
               state_d = StFlush;
            end else if (table_cout) begin
               state_d = StInRd;
            end else begin
               state_d = StInRd1;
            end
         end
         StFlush: begin
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   conv_ctrl_decode u_decode (
      .state     (state_q),
      .row_idx   (row_q),
      .wr_fill   (fill_q),
      .ctrl      (ctrl_word),
      .mem_read  (mem_read),
      .mem_write (mem_write)
   );

   assign ctrl = ctrl_word;

   // Handshake outputs decoded from state.
   always_comb begin
      busy = (state_q != StIdle) && (state_q != StDone);
      done = (state_q == StDone);
   end

   // The memory port is shared: a read and a write must never be issued together.
   a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_conv_controller.sv
// Directed bench for conv_controller: a small datapath stub produces the counter wrap
// flags from the control word, a negedge monitor tallies control activity, and each run
// is checked against hand-computed totals.
module tb_conv_controller;
   import conv_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        filt_cout, input_j_cout, calc_done, write_mem_cout, table_cout, it_ends;
   logic [29:0] ctrl;
   logic        mem_read, mem_write, busy, done;

   int chk_cnt = 0;
   int err_cnt = 0;

   // Window-level stimulus knobs.
   logic [3:0]  last_win = 4'd0;
   logic [15:0] tab_pat  = 16'h0000;

   conv_controller #(
      .ADDR_W (7),
      .CTRL_W (30)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .filt_cout      (filt_cout),
      .input_j_cout   (input_j_cout),
      .calc_done      (calc_done),
      .write_mem_cout (write_mem_cout),
      .table_cout     (table_cout),
      .it_ends        (it_ends),
      .ctrl           (ctrl),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   // Datapath stub counters.
   logic [1:0] filt_cnt, in_j_cnt, wr_cnt;
   logic [3:0] calc_cnt, win_cnt;

   always @(posedge clk) begin
      if (!rst || ctrl[TAB_COUNT_LD]) begin
         filt_cnt <= 2'd0;
         in_j_cnt <= 2'd0;
         wr_cnt   <= 2'd0;
         calc_cnt <= 4'd0;
         win_cnt  <= 4'd0;
      end else begin
         if (ctrl[FILT_COUNT_EN])  filt_cnt <= filt_cnt + 2'd1;
         if (ctrl[INPUT_COUNT_EN]) in_j_cnt <= in_j_cnt + 2'd1;
         if (ctrl[WR_COUNT_EN])    wr_cnt   <= wr_cnt + 2'd1;
         if (ctrl[CALC_COUNT_EN])  calc_cnt <= calc_cnt + 4'd1;
         if (ctrl[SHIFT_EN])       win_cnt  <= win_cnt + 4'd1;
      end
   end

   assign filt_cout      = ctrl[FILT_COUNT_EN] && (filt_cnt == 2'd3);
   assign input_j_cout   = ctrl[INPUT_COUNT_EN] && (in_j_cnt == 2'd3);
   assign calc_done      = ctrl[CALC_COUNT_EN] && (calc_cnt == 4'd15);
   assign write_mem_cout = ctrl[WR_COUNT_EN] && (wr_cnt == 2'd3);
   assign table_cout     = ctrl[SHIFT_EN] && tab_pat[win_cnt];
   assign it_ends        = ctrl[SHIFT_EN] && (win_cnt == last_win);

   // Monitor tallies, indexed by these slots.
   localparam int M_FILT  = 0;  // reads from x
   localparam int M_IN    = 1;  // reads from y
   localparam int M_MAC   = 2;  // mac_ld cycles
   localparam int M_WBUF  = 3;  // write_buf_ld pulses
   localparam int M_WR    = 4;  // mem_write cycles
   localparam int M_WRZ   = 5;  // mem_write with mem_in_sel = z
   localparam int M_FLUSH = 6;  // mem_write with wr_data_sel = 1
   localparam int M_DONE  = 7;  // done cycles
   localparam int M_DBUSY = 8;  // done together with busy
   localparam int M_RW    = 9;  // read and write together
   localparam int M_TAB   = 10; // table_ld pulses
   localparam int M_N     = 11;

   int          mon  [M_N];
   int          base [M_N];
   logic [1:0]  isel_q [$];

   initial for (int i = 0; i < M_N; i++) mon[i] = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (mem_read && ctrl[MEM_IN_SEL +: 2] == 2'd0) mon[M_FILT] <= mon[M_FILT] + 1;
         if (mem_read && ctrl[MEM_IN_SEL +: 2] == 2'd1) begin
            mon[M_IN] <= mon[M_IN] + 1;
            isel_q.push_back(ctrl[INPUT_I_SEL +: 2]);
         end
         if (ctrl[MAC_LD])       mon[M_MAC]  <= mon[M_MAC] + 1;
         if (ctrl[WRITE_BUF_LD]) mon[M_WBUF] <= mon[M_WBUF] + 1;
         if (mem_write)          mon[M_WR]   <= mon[M_WR] + 1;
         if (mem_write && ctrl[MEM_IN_SEL +: 2] == 2'd2) mon[M_WRZ] <= mon[M_WRZ] + 1;
         if (mem_write && ctrl[WR_DATA_SEL]) mon[M_FLUSH] <= mon[M_FLUSH] + 1;
         if (done)               mon[M_DONE]  <= mon[M_DONE] + 1;
         if (done && busy)       mon[M_DBUSY] <= mon[M_DBUSY] + 1;
         if (mem_read && mem_write) mon[M_RW] <= mon[M_RW] + 1;
         if (ctrl[TABLE_LD])     mon[M_TAB]  <= mon[M_TAB] + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      for (int i = 0; i < M_N; i++) base[i] = mon[i];
   endtask

   function automatic logic [31:0] delta(input int slot);
      return 32'(mon[slot] - base[slot]);
   endfunction

   // Pulse start for one cycle; returns at the negedge where the DUT sits in INIT.
   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
      @(negedge clk);
      check_eq({tag, "_idle_ctrl"}, 32'(ctrl), 32'h0020_0000);
      check_eq({tag, "_idle_busy_done"}, {30'd0, busy, done}, 32'd0);
   endtask

   task automatic wait_mac(input string tag, input int budget);
      int n = 0;
      while (!ctrl[MAC_LD] && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_mac_seen"}, 32'(ctrl[MAC_LD]), 32'd1);
   endtask

   initial begin
      int ib;
      int bad;

      // Reset state.
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ctrl", 32'(ctrl), 32'h0020_0000);
      check_eq("rst_flags", {28'd0, mem_read, mem_write, busy, done}, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Run 1: six windows, full refetch after window 2, end with two results buffered.
      last_win = 4'd5;
      tab_pat  = 16'h0004;
      snap();
      ib = isel_q.size();
      kick();
      check_eq("init_ctrl", 32'(ctrl), 32'h0220_0524);
      check_eq("init_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check_eq("filt_ctrl", 32'(ctrl), 32'h0000_1205);
      check_eq("filt_read", {30'd0, mem_read, mem_write}, 32'd2);
      wait_done("r1", 2000);
      check_eq("r1_filt_reads", delta(M_FILT), 32'd4);
      check_eq("r1_in_reads", delta(M_IN), 32'd48);
      check_eq("r1_mac_cycles", delta(M_MAC), 32'd96);
      check_eq("r1_wbuf_pulses", delta(M_WBUF), 32'd6);
      check_eq("r1_table_ld", delta(M_TAB), 32'd6);
      check_eq("r1_mem_writes", delta(M_WR), 32'd2);
      check_eq("r1_writes_to_z", delta(M_WRZ), 32'd2);
      check_eq("r1_flush_writes", delta(M_FLUSH), 32'd1);
      check_eq("r1_done_cycles", delta(M_DONE), 32'd1);
      check_eq("r1_done_busy", delta(M_DBUSY), 32'd0);
      check_eq("r1_rw_overlap", delta(M_RW), 32'd0);
      // Row select: full fetch walks rows in groups of four, single refresh walks 0..3.
      bad = 0;
      for (int k = 0; k < 16; k++) if (isel_q[ib + k] != 2'(k / 4)) bad++;
      for (int k = 0; k < 4; k++)  if (isel_q[ib + 16 + k] != 2'(k)) bad++;
      check_eq("r1_row_select", 32'(bad), 32'd0);

      // Run 2: it_ends and table_cout together after one window; start pulsed in CALC.
      last_win = 4'd0;
      tab_pat  = 16'h0001;
      snap();
      kick();
      wait_mac("r2", 200);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_done("r2", 500);
      check_eq("r2_in_reads", delta(M_IN), 32'd16);
      check_eq("r2_mac_cycles", delta(M_MAC), 32'd16);
      check_eq("r2_flush_writes", delta(M_FLUSH), 32'd1);
      check_eq("r2_mem_writes", delta(M_WR), 32'd1);
      check_eq("r2_done_cycles", delta(M_DONE), 32'd1);
      repeat (4) @(negedge clk);
      check_eq("r2_no_restart", 32'(busy), 32'd0);

      // Run 3: reset held two cycles in the middle of CALC aborts the run.
      last_win = 4'd5;
      tab_pat  = 16'h0000;
      snap();
      kick();
      wait_mac("r3", 200);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("r3_rst_ctrl", 32'(ctrl), 32'h0020_0000);
      check_eq("r3_rst_flags", {28'd0, mem_read, mem_write, busy, done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("r3_post_ctrl", 32'(ctrl), 32'h0020_0000);
      check_eq("r3_post_busy", 32'(busy), 32'd0);
      check_eq("r3_no_writes", delta(M_WR), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
